// File: rtl/scan_pkg.sv
// ---------------------------------------------------------------------------
// scan_pkg
//   Shared definitions for the ROM window scanner: image geometry, the
//   controller state encoding and the packed 3x3 window layout.
//   Contents:
//     IMG_W / IMG_H / ADDR_W  image width (= ROM word width), valid rows,
//                             ROM row-address width
//     COORD_W                 width of the x / y pixel coordinates
//     X_LAST / Y_LAST         last column / last row as coordinate-width values
//     state_t                 IDLE, LOAD0, LOAD1, SCAN
//     win_t                   {top, mid, bot}, each {L, C, R}
//     fetch_addr()            maps a wanted row to a ROM address, 0 past the image
// ---------------------------------------------------------------------------
package scan_pkg;

  localparam int IMG_W   = 64;
  localparam int IMG_H   = 48;
  localparam int ADDR_W  = 6;
  localparam int COORD_W = 6;

  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(IMG_W - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(IMG_H - 1);

  // Row numbers one bit wider than a coordinate so y+2 / y+3 never wrap
  // before being compared against the image height.
  localparam logic [COORD_W:0] IMG_H_EXT = (COORD_W + 1)'(IMG_H);

  typedef enum logic [1:0] {
    IDLE,
    LOAD0,
    LOAD1,
    SCAN
  } state_t;

  typedef struct packed {
    logic [2:0] top;
    logic [2:0] mid;
    logic [2:0] bot;
  } win_t;

  // Rows at or beyond the image height are never fetched; the address
  // parks at 0 instead.
  function automatic logic [ADDR_W-1:0] fetch_addr(input logic [COORD_W:0] row);
    logic [ADDR_W-1:0] addr;
    addr = '0;
    if (row < IMG_H_EXT) begin
      addr = row[ADDR_W-1:0];
    end
    return addr;
  endfunction

endpackage

// File: rtl/row_tap.sv
// ---------------------------------------------------------------------------
// row_tap
//   Extracts the three horizontally adjacent pixels {L, C, R} around column x
//   from one image row word. Pixel x lives at bit [IMG_W-1-x], so the MSB is
//   the leftmost pixel. Columns outside the row read as 0.
//   Ports:
//     row  in   IMG_W    row word
//     x    in   COORD_W  centre column
//     tap  out  3        {left, centre, right}
// ---------------------------------------------------------------------------
module row_tap
  import scan_pkg::*;
(
  input  logic [IMG_W-1:0]   row,
  input  logic [COORD_W-1:0] x,
  output logic [2:0]         tap
);

  logic left_px;
  logic centre_px;
  logic right_px;

  // With IMG_W == 2**COORD_W, bit IMG_W-1-x is simply ~x, so every index
  // stays exactly COORD_W wide. x-1 and x+1 are only used away from the
  // edges, where they cannot wrap.
  always_comb begin
    centre_px = row[~x];
    left_px   = 1'b0;
    right_px  = 1'b0;
    if (x != '0) begin
      left_px = row[~(x - COORD_W'(1))];
    end
    if (x != X_LAST) begin
      right_px = row[~(x + COORD_W'(1))];
    end
    tap = {left_px, centre_px, right_px};
  end

endmodule

// File: rtl/rom_window_scanner.sv
// ---------------------------------------------------------------------------
// rom_window_scanner
//   Reads the binary image ROM one row at a time and streams a 3x3 pixel
//   neighbourhood for every pixel in raster order over a valid/ready stream.
//   Three row buffers (prv / cur / nxt) hold rows y-1, y and y+1; each image
//   row is fetched exactly once per frame and pixels outside the image read
//   as 0.
//   Ports:
//     clk        in   1        rising-edge clock
//     rst_n      in   1        asynchronous active-low reset
//     start      in   1        starts a frame when the block is idle
//     abort      in   1        synchronous return to idle, no done pulse
//     rom_addr   out  ADDR_W   registered ROM row address
//     rom_data   in   IMG_W    combinational ROM word for rom_addr
//     win_valid  out  1        window valid
//     win_ready  in   1        downstream accepts the window
//     win        out  9        {top[L,C,R], mid[L,C,R], bot[L,C,R]}
//     win_x      out  6        centre column
//     win_y      out  6        centre row
//     busy       out  1        frame in progress (LOAD0, LOAD1, SCAN)
//     done       out  1        one-cycle pulse after the last window is taken
// ---------------------------------------------------------------------------
module rom_window_scanner
  import scan_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [IMG_W-1:0]   rom_data,
  output logic               win_valid,
  input  logic               win_ready,
  output logic [8:0]         win,
  output logic [COORD_W-1:0] win_x,
  output logic [COORD_W-1:0] win_y,
  output logic               busy,
  output logic               done
);

  state_t               state_q,     state_d;
  logic [ADDR_W-1:0]    rom_addr_q,  rom_addr_d;
  logic [IMG_W-1:0]     prv_q,       prv_d;
  logic [IMG_W-1:0]     cur_q,       cur_d;
  logic [IMG_W-1:0]     nxt_q,       nxt_d;
  logic [COORD_W-1:0]   x_q,         x_d;
  logic [COORD_W-1:0]   y_q,         y_d;
  logic                 win_valid_q, win_valid_d;
  logic                 busy_q,      busy_d;
  logic                 done_q,      done_d;

  logic                 handshake;
  logic                 last_col;
  logic                 last_row;
  logic [COORD_W:0]     y_ext;
  logic [COORD_W:0]     row_after_next;
  logic [COORD_W:0]     row_to_prefetch;
  win_t                 win_s;

  // One tap per buffered row; together they form the 3x3 window.
  row_tap u_tap_prv (
    .row (prv_q),
    .x   (x_q),
    .tap (win_s.top)
  );

  row_tap u_tap_cur (
    .row (cur_q),
    .x   (x_q),
    .tap (win_s.mid)
  );

  row_tap u_tap_nxt (
    .row (nxt_q),
    .x   (x_q),
    .tap (win_s.bot)
  );

  assign handshake = (state_q == SCAN) && win_ready;
  assign last_col  = (x_q == X_LAST);
  assign last_row  = (y_q == Y_LAST);

  // While scanning row y the ROM is already addressed at row y+2, so on the
  // row advance rom_data is the new bottom row (y+1)+1 and the address moves
  // on to y+3 for the advance after that.
  assign y_ext           = {1'b0, y_q};
  assign row_after_next  = y_ext + (COORD_W + 1)'(2);
  assign row_to_prefetch = y_ext + (COORD_W + 1)'(3);

  // Next-state and datapath logic. Abort is applied last so it overrides
  // every transition, including the final handshake of a frame. Buffers
  // and coordinates are cleared whenever the block returns to idle so the
  // window outputs read as zero outside a frame.
  always_comb begin
    state_d     = state_q;
    rom_addr_d  = rom_addr_q;
    prv_d       = prv_q;
    cur_d       = cur_q;
    nxt_d       = nxt_q;
    x_d         = x_q;
    y_d         = y_q;
    win_valid_d = win_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = LOAD0;
          busy_d     = 1'b1;
          rom_addr_d = '0;
        end
      end

      LOAD0: begin
        cur_d      = rom_data;
        rom_addr_d = ADDR_W'(1);
        state_d    = LOAD1;
      end

      LOAD1: begin
        nxt_d       = rom_data;
        prv_d       = '0;
        rom_addr_d  = ADDR_W'(2);
        x_d         = '0;
        y_d         = '0;
        win_valid_d = 1'b1;
        state_d     = SCAN;
      end

      SCAN: begin
        if (handshake) begin
          if (!last_col) begin
            x_d = x_q + COORD_W'(1);
          end else if (!last_row) begin
            prv_d      = cur_q;
            cur_d      = nxt_q;
            nxt_d      = (row_after_next < IMG_H_EXT) ? rom_data : '0;
            rom_addr_d = fetch_addr(row_to_prefetch);
            x_d        = '0;
            y_d        = y_q + COORD_W'(1);
          end else begin
            state_d     = IDLE;
            win_valid_d = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            rom_addr_d  = '0;
            prv_d       = '0;
            cur_d       = '0;
            nxt_d       = '0;
            x_d         = '0;
            y_d         = '0;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (abort) begin
      state_d     = IDLE;
      rom_addr_d  = '0;
      prv_d       = '0;
      cur_d       = '0;
      nxt_d       = '0;
      x_d         = '0;
      y_d         = '0;
      win_valid_d = 1'b0;
      busy_d      = 1'b0;
      done_d      = 1'b0;
    end
  end

  // Controller, counters, row buffers and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rom_addr_q  <= '0;
      prv_q       <= '0;
      cur_q       <= '0;
      nxt_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      win_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rom_addr_q  <= rom_addr_d;
      prv_q       <= prv_d;
      cur_q       <= cur_d;
      nxt_q       <= nxt_d;
      x_q         <= x_d;
      y_q         <= y_d;
      win_valid_q <= win_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign win_valid = win_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign win       = win_s;
  assign win_x     = x_q;
  assign win_y     = y_q;

endmodule

// File: tb/tb_rom_window_scanner.sv
// ---------------------------------------------------------------------------
// tb_rom_window_scanner
//   Drives rom_window_scanner against a behavioural image ROM and compares
//   every accepted window with a neighbourhood model computed straight from
//   the image array.
// ---------------------------------------------------------------------------
module tb_rom_window_scanner;

  localparam int W      = 64;
  localparam int H      = 48;
  localparam int NWIN   = W * H;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [5:0]  rom_addr;
  logic [63:0] rom_data;
  logic        win_valid;
  logic        win_ready;
  logic [8:0]  win;
  logic [5:0]  win_x;
  logic [5:0]  win_y;
  logic        busy;
  logic        done;

  logic [63:0] image [64];

  int          n_checks;
  int          n_errors;
  int          exp_idx;
  bit          chk_en;
  bit          stall_prev;
  logic [20:0] held;

  int          pin_x [3] = '{11, 0, 63};
  int          pin_y [3] = '{0, 23, 47};
  logic [8:0]  pin_w [3] = '{9'b000_111_111, 9'b000_011_011, 9'b110_110_000};

  rom_window_scanner dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .win       (win),
    .win_x     (win_x),
    .win_y     (win_y),
    .busy      (busy),
    .done      (done)
  );

  assign rom_data = image[rom_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Image model: pixel (x, y) is bit 63-x of row y, zero outside the image.
  function automatic logic pix(input int x, input int y);
    logic [63:0] r;
    if (x < 0 || x >= W || y < 0 || y >= H) return 1'b0;
    r = image[y];
    return r[63 - x];
  endfunction

  function automatic logic [8:0] model_win(input int x, input int y);
    logic [8:0] w;
    int k;
    k = 8;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        w[k] = pix(x + dx, y + dy);
        k--;
      end
    end
    return w;
  endfunction

  task automatic set_px(input int x, input int y, input logic v);
    logic [63:0] r;
    r = image[y];
    r[63 - x] = v;
    image[y] = r;
  endtask

  // Compare process: every accepted window must be the next one in raster
  // order, match the model, and stalled windows must not change.
  always @(negedge clk) begin
    if (!rst_n || !chk_en) begin
      stall_prev = 1'b0;
    end else begin
      if (win_valid) begin
        if (stall_prev) begin
          checkOutput("stall_hold", 32'({win, win_x, win_y}), 32'(held));
        end
        if (win_ready) begin
          if (exp_idx >= NWIN) begin
            checkOutput("extra_window", 32'(exp_idx), 32'(NWIN - 1));
          end else begin
            int ex;
            int ey;
            ex = exp_idx % W;
            ey = exp_idx / W;
            checkOutput("win_x", 32'(win_x), 32'(ex));
            checkOutput("win_y", 32'(win_y), 32'(ey));
            checkOutput("win", 32'(win), 32'(model_win(ex, ey)));
            checkOutput("rom_addr_in_row", 32'(rom_addr), 32'((ey + 2 < H) ? ey + 2 : 0));
            for (int i = 0; i < 3; i++) begin
              if (ex == pin_x[i] && ey == pin_y[i]) begin
                checkOutput("pinned_win", 32'(win), 32'(pin_w[i]));
              end
            end
            if (ex == 0 && ey == 23) begin
              checkOutput("pinned_rom_addr", 32'(rom_addr), 32'd25);
            end
          end
          exp_idx++;
        end
        stall_prev = !win_ready;
        held       = {win, win_x, win_y};
      end else begin
        stall_prev = 1'b0;
      end
      if (done) begin
        checkOutput("done_after_all_windows", 32'(exp_idx), 32'(NWIN));
      end
    end
  end

  // Raises start for one sampled edge; returns just after that edge.
  task automatic start_frame();
    @(posedge clk); #1;
    start   = 1'b1;
    exp_idx = 0;
    chk_en  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic applyStimulus(input bit rand_ready, input bit poke_start, input int expect_cycles);
    int  n;
    bit  seen;
    win_ready = 1'b1;
    start_frame();
    n    = 0;
    seen = 1'b0;
    checkOutput("load0_rom_addr", 32'(rom_addr), 32'd0);
    checkOutput("busy_after_start", 32'(busy), 32'd1);
    while (n < 10000) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        checkOutput("valid_low_in_load1", 32'(win_valid), 32'd0);
        checkOutput("load1_rom_addr", 32'(rom_addr), 32'd1);
      end
      if (n == 2) begin
        checkOutput("first_valid", 32'(win_valid), 32'd1);
        checkOutput("first_xy", 32'({win_x, win_y}), 32'd0);
      end
      if (done) begin
        seen = 1'b1;
        break;
      end
      win_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      start     = poke_start && (n % 400 == 0);
    end
    start     = 1'b0;
    win_ready = 1'b1;
    if (!seen) begin
      checkOutput("done_timeout", 32'(seen), 32'd1);
    end else begin
      checkOutput("busy_at_done", 32'(busy), 32'd0);
      checkOutput("valid_at_done", 32'(win_valid), 32'd0);
      checkOutput("handshake_count", 32'(exp_idx), 32'(NWIN));
      if (expect_cycles != 0) begin
        checkOutput("done_latency", 32'(n), 32'(expect_cycles));
      end
      @(posedge clk); #1;
      checkOutput("done_one_cycle", 32'(done), 32'd0);
    end
  endtask

  task automatic applyAbort(input int ax, input int ay);
    bit found;
    bit saw_done;
    win_ready = 1'b1;
    start_frame();
    found = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      @(posedge clk); #1;
      if (win_valid && win_x == 6'(ax) && win_y == 6'(ay)) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("abort_target_reached", 32'(found), 32'd1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort  = 1'b0;
    chk_en = 1'b0;
    checkOutput("abort_valid", 32'(win_valid), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_rom_addr", 32'(rom_addr), 32'd0);
    saw_done = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      saw_done |= done;
    end
    checkOutput("abort_no_late_done", 32'(saw_done), 32'd0);
  endtask

  task automatic applyResetMidFrame();
    bit saw_done;
    win_ready = 1'b1;
    start_frame();
    repeat (1000) @(posedge clk);
    @(negedge clk); #2;
    chk_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    checkOutput("rst_valid", 32'(win_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_rom_addr", 32'(rom_addr), 32'd0);
    checkOutput("rst_win", 32'(win), 32'd0);
    checkOutput("rst_xy", 32'({win_x, win_y}), 32'd0);
    saw_done = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      saw_done |= done;
    end
    checkOutput("rst_no_done", 32'(saw_done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    exp_idx    = 0;
    chk_en     = 1'b0;
    stall_prev = 1'b0;
    held       = '0;
    rst_n      = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    win_ready  = 1'b0;

    // Rows past the image are all ones so any stray fetch shows up.
    for (int r = 0; r < 64; r++) begin
      image[r] = (r < H) ? {$urandom, $urandom} : '1;
    end
    for (int x = 10; x <= 12; x++) begin
      set_px(x, 0, 1'b1);
      set_px(x, 1, 1'b1);
    end
    for (int x = 0; x <= 1; x++) begin
      set_px(x, 22, 1'b0);
      set_px(x, 23, 1'b1);
      set_px(x, 24, 1'b1);
    end
    for (int x = 62; x <= 63; x++) begin
      set_px(x, 46, 1'b1);
      set_px(x, 47, 1'b1);
    end

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_valid", 32'(win_valid), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_rom_addr", 32'(rom_addr), 32'd0);
    checkOutput("reset_win", 32'(win), 32'd0);
    checkOutput("reset_xy", 32'({win_x, win_y}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(1'b0, 1'b0, 3074);
    applyStimulus(1'b1, 1'b0, 0);
    applyStimulus(1'b1, 1'b1, 0);
    applyAbort(5, 10);
    applyStimulus(1'b0, 1'b0, 3074);
    applyAbort(63, 47);
    applyResetMidFrame();
    applyStimulus(1'b0, 1'b0, 3074);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
